// File: rtl/axil_mem_dual.sv
// axil_mem_dual: AXI4-Lite slave SRAM with independent read and write channels.
// AW and W may arrive in either order; writes honour per-byte strobes.
// Build option: define AXIL_MEM_RANGE_CHK_EN to answer SLVERR for addresses
// beyond the memory (writes dropped, reads return 0). Without it, upper
// address bits are ignored and the memory aliases.
module axil_mem_dual #(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [DATA_WIDTH-1:0]       s_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0]     s_axi_wstrb,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    output logic [1:0]                  s_axi_bresp,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    output logic [DATA_WIDTH-1:0]       s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LSB    = $clog2(STRB_W);
    localparam int DEPTH  = 2 ** ADDR_WIDTH;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_data_width
        $error("axil_mem_dual: DATA_WIDTH must be 32 or 64");
    end
    if (AXI_ADDR_WIDTH < ADDR_WIDTH + LSB) begin : g_bad_addr_width
        $error("axil_mem_dual: AXI_ADDR_WIDTH too narrow for ADDR_WIDTH");
    end

    // Storage; contents are deliberately left unreset.
    logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

    // Word indices and range flags for the live AW and AR addresses
    logic [ADDR_WIDTH-1:0] aw_idx;
    logic [ADDR_WIDTH-1:0] ar_idx;
    logic                  aw_oor;
    logic                  ar_oor;

    assign aw_idx = s_axi_awaddr[ADDR_WIDTH+LSB-1:LSB];
    assign ar_idx = s_axi_araddr[ADDR_WIDTH+LSB-1:LSB];

`ifdef AXIL_MEM_RANGE_CHK_EN
    // Any set bit above the word index means the address misses the memory.
    function automatic logic out_of_range(input logic [AXI_ADDR_WIDTH-1:0] addr);
        return (addr >> (ADDR_WIDTH + LSB)) != '0;
    endfunction

    assign aw_oor = out_of_range(s_axi_awaddr);
    assign ar_oor = out_of_range(s_axi_araddr);
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Byte-lane bits and (without range checking) the upper bits are don't-care.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr, s_axi_araddr};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        W_IDLE    = 2'd0,
        W_HAVE_AW = 2'd1,
        W_HAVE_W  = 2'd2,
        W_RESP    = 2'd3
    } w_state_t;

    w_state_t w_state;
    w_state_t w_next;

    logic aw_hsk;
    logic w_hsk;
    logic b_hsk;

    assign aw_hsk = s_axi_awvalid && s_axi_awready;
    assign w_hsk  = s_axi_wvalid  && s_axi_wready;
    assign b_hsk  = s_axi_bvalid  && s_axi_bready;

    // First-arriving half of a write, parked until its partner arrives
    logic [ADDR_WIDTH-1:0] aw_idx_q;
    logic                  aw_oor_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;

    // Write that lands in memory on this edge
    logic                  commit_en;
    logic [ADDR_WIDTH-1:0] commit_idx;
    logic                  commit_oor;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [STRB_W-1:0]     commit_strb;

    logic       awready_nxt;
    logic       wready_nxt;
    logic       bvalid_nxt;
    logic [1:0] bresp_nxt;

    // Pick address and data from the live bus or the parked copy
    always_comb begin
        commit_en   = 1'b0;
        commit_idx  = aw_idx;
        commit_oor  = aw_oor;
        commit_data = s_axi_wdata;
        commit_strb = s_axi_wstrb;
        case (w_state)
            W_IDLE: begin
                commit_en = aw_hsk && w_hsk;
            end
            W_HAVE_AW: begin
                commit_en  = w_hsk;
                commit_idx = aw_idx_q;
                commit_oor = aw_oor_q;
            end
            W_HAVE_W: begin
                commit_en   = aw_hsk;
                commit_data = wdata_q;
                commit_strb = wstrb_q;
            end
            default: begin
                commit_en = 1'b0;
            end
        endcase
    end

    // Write FSM next state
    always_comb begin
        w_next = w_state;
        case (w_state)
            W_IDLE: begin
                if (commit_en) begin
                    w_next = W_RESP;
                end else if (aw_hsk) begin
                    w_next = W_HAVE_AW;
                end else if (w_hsk) begin
                    w_next = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (commit_en) begin
                    w_next = W_RESP;
                end
            end
            W_HAVE_W: begin
                if (commit_en) begin
                    w_next = W_RESP;
                end
            end
            W_RESP: begin
                if (b_hsk) begin
                    w_next = W_IDLE;
                end
            end
            default: begin
                w_next = W_IDLE;
            end
        endcase
    end

    // Write FSM outputs, decoded from the next state so they can be registered
    always_comb begin
        awready_nxt = (w_next == W_IDLE) || (w_next == W_HAVE_W);
        wready_nxt  = (w_next == W_IDLE) || (w_next == W_HAVE_AW);
        bvalid_nxt  = (w_next == W_RESP);
        bresp_nxt   = RESP_OKAY;
        if (w_next == W_RESP) begin
            if (w_state == W_RESP) begin
                bresp_nxt = s_axi_bresp;
            end else if (commit_oor) begin
                bresp_nxt = RESP_SLVERR;
            end
        end
    end

    // Write FSM state register and registered channel outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state       <= W_IDLE;
            s_axi_awready <= 1'b0;
            s_axi_wready  <= 1'b0;
            s_axi_bvalid  <= 1'b0;
            s_axi_bresp   <= RESP_OKAY;
        end else begin
            w_state       <= w_next;
            s_axi_awready <= awready_nxt;
            s_axi_wready  <= wready_nxt;
            s_axi_bvalid  <= bvalid_nxt;
            s_axi_bresp   <= bresp_nxt;
        end
    end

    // Park whichever half of the write arrives first; stale copies are never
    // used because the FSM restarts in W_IDLE after reset.
    always_ff @(posedge clk) begin
        if (w_state == W_IDLE) begin
            if (aw_hsk) begin
                aw_idx_q <= aw_idx;
                aw_oor_q <= aw_oor;
            end
            if (w_hsk) begin
                wdata_q <= s_axi_wdata;
                wstrb_q <= s_axi_wstrb;
            end
        end
    end

    // Byte-strobed memory update; out-of-range writes leave memory untouched
    always_ff @(posedge clk) begin
        if (commit_en && !commit_oor) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (commit_strb[i]) begin
                    mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

    r_state_t r_state;
    r_state_t r_next;

    logic ar_hsk;
    logic r_hsk;
    logic arready_nxt;
    logic rvalid_nxt;

    assign ar_hsk = s_axi_arvalid && s_axi_arready;
    assign r_hsk  = s_axi_rvalid  && s_axi_rready;

    // Read FSM next state
    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (ar_hsk) begin
                    r_next = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hsk) begin
                    r_next = R_IDLE;
                end
            end
            default: begin
                r_next = R_IDLE;
            end
        endcase
    end

    // Read FSM outputs, decoded from the next state so they can be registered
    always_comb begin
        arready_nxt = (r_next == R_IDLE);
        rvalid_nxt  = (r_next == R_DATA);
    end

    // Read FSM state register and registered channel outputs. The memory is
    // sampled before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= R_IDLE;
            s_axi_arready <= 1'b0;
            s_axi_rvalid  <= 1'b0;
            s_axi_rdata   <= '0;
            s_axi_rresp   <= RESP_OKAY;
        end else begin
            r_state       <= r_next;
            s_axi_arready <= arready_nxt;
            s_axi_rvalid  <= rvalid_nxt;
            if (ar_hsk) begin
                if (ar_oor) begin
                    s_axi_rdata <= '0;
                    s_axi_rresp <= RESP_SLVERR;
                end else begin
                    s_axi_rdata <= mem[ar_idx];
                    s_axi_rresp <= RESP_OKAY;
                end
            end
        end
    end

endmodule

// File: tb/tb_axil_mem_dual.sv
// Directed bench for axil_mem_dual with a transaction-level reference model.
module tb_axil_mem_dual;

    localparam int AW  = 10;
    localparam int DW  = 32;
    localparam int AXW = 32;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AXW-1:0]  s_axi_awaddr;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [DW-1:0]   s_axi_wdata;
    logic [DW/8-1:0] s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [AXW-1:0]  s_axi_araddr;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [DW-1:0]   s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;

    axil_mem_dual #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .AXI_ADDR_WIDTH (AXW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tmo(input string name);
        total++;
        bad++;
        $display("FAIL %s: no handshake within cycle budget at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] d;
        logic [3:0]  s;
    } wbeat_t;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  r;
    } rbeat_t;

    logic [31:0] mdl [0:1023];
    logic [31:0] awq [$];
    wbeat_t      wq  [$];
    logic [1:0]  bq  [$];
    rbeat_t      rq  [$];
    bit          live = 1'b0;

    function automatic bit mdl_oor(input logic [31:0] a);
        bit en;
`ifdef AXIL_MEM_RANGE_CHK_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        return en && (a >= 32'd4096);
    endfunction

    function automatic int mdl_word(input logic [31:0] a);
        return int'((a % 32'd4096) / 32'd4);
    endfunction

    // Track accepted transactions at each rising edge (pre-edge values)
    always @(posedge clk) begin : model
        logic [31:0] a;
        logic [31:0] word;
        wbeat_t      wb;
        rbeat_t      e;
        if (!rst_n) begin
            awq.delete();
            wq.delete();
            bq.delete();
            rq.delete();
            live = 1'b0;
        end else begin
            live = 1'b1;
            if (s_axi_bvalid && s_axi_bready && bq.size() > 0) void'(bq.pop_front());
            if (s_axi_rvalid && s_axi_rready && rq.size() > 0) void'(rq.pop_front());
            if (s_axi_arvalid && s_axi_arready) begin
                if (mdl_oor(s_axi_araddr)) begin
                    e.d = 32'h0;
                    e.r = 2'b10;
                end else begin
                    e.d = mdl[mdl_word(s_axi_araddr)];
                    e.r = 2'b00;
                end
                rq.push_back(e);
            end
            if (s_axi_awvalid && s_axi_awready) awq.push_back(s_axi_awaddr);
            if (s_axi_wvalid && s_axi_wready) begin
                wb.d = s_axi_wdata;
                wb.s = s_axi_wstrb;
                wq.push_back(wb);
            end
            if (awq.size() > 0 && wq.size() > 0) begin
                a  = awq.pop_front();
                wb = wq.pop_front();
                if (mdl_oor(a)) begin
                    bq.push_back(2'b10);
                end else begin
                    word = mdl[mdl_word(a)];
                    for (int i = 0; i < 4; i++) begin
                        if (wb.s[i]) word[8*i +: 8] = wb.d[8*i +: 8];
                    end
                    mdl[mdl_word(a)] = word;
                    bq.push_back(2'b00);
                end
            end
        end
    end

    // Compare DUT outputs against the model on every falling edge
    always @(negedge clk) begin
        if (rst_n && live) begin
            chk("awready", 32'(s_axi_awready), 32'(bq.size() == 0 && awq.size() == 0));
            chk("wready",  32'(s_axi_wready),  32'(bq.size() == 0 && wq.size() == 0));
            chk("bvalid",  32'(s_axi_bvalid),  32'(bq.size() != 0));
            chk("arready", 32'(s_axi_arready), 32'(rq.size() == 0));
            chk("rvalid",  32'(s_axi_rvalid),  32'(rq.size() != 0));
            if (bq.size() > 0) chk("bresp", 32'(s_axi_bresp), 32'(bq[0]));
            if (rq.size() > 0) begin
                chk("rdata", s_axi_rdata, rq[0].d);
                chk("rresp", 32'(s_axi_rresp), 32'(rq[0].r));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send_aw(input logic [31:0] a);
        int n;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_axi_awready) break;
        end
        if (n == 100) tmo("aw_handshake");
        @(posedge clk);
        #1;
        s_axi_awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_axi_wready) break;
        end
        if (n == 100) tmo("w_handshake");
        @(posedge clk);
        #1;
        s_axi_wvalid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] a);
        int n;
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_axi_arready) break;
        end
        if (n == 100) tmo("ar_handshake");
        @(posedge clk);
        #1;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic wait_b(output logic [1:0] resp, output int cyc);
        int n;
        resp = 2'bxx;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_axi_bvalid) begin
                resp = s_axi_bresp;
                break;
            end
        end
        if (n == 100) tmo("b_response");
        cyc = n;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_r(output logic [31:0] d, output logic [1:0] resp, output int cyc);
        int n;
        d    = 32'hxxxxxxxx;
        resp = 2'bxx;
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (s_axi_rvalid) begin
                d    = s_axi_rdata;
                resp = s_axi_rresp;
                break;
            end
        end
        if (n == 100) tmo("r_response");
        cyc = n;
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         output logic [1:0] resp);
        int cyc;
        fork
            send_aw(a);
            send_w(d, s);
        join
        wait_b(resp, cyc);
    endtask

    task automatic read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        send_ar(a);
        wait_r(d, resp, cyc);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_awready"}, 32'(s_axi_awready), 32'h0);
        chk({tag, "_wready"},  32'(s_axi_wready),  32'h0);
        chk({tag, "_arready"}, 32'(s_axi_arready), 32'h0);
        chk({tag, "_bvalid"},  32'(s_axi_bvalid),  32'h0);
        chk({tag, "_rvalid"},  32'(s_axi_rvalid),  32'h0);
        chk({tag, "_bresp"},   32'(s_axi_bresp),   32'h0);
        chk({tag, "_rresp"},   32'(s_axi_rresp),   32'h0);
        chk({tag, "_rdata"},   s_axi_rdata,        32'h0);
    endtask

    // Hard stop in case something wedges outside a bounded wait
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [1:0]  resp;
        logic [1:0]  rresp;
        logic [31:0] rd;
        int          cyc;
        int          cyc2;

        rst_n         = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rel_awready", 32'(s_axi_awready), 32'h1);
        chk("rel_wready",  32'(s_axi_wready),  32'h1);
        chk("rel_arready", 32'(s_axi_arready), 32'h1);
        @(posedge clk);
        #1;

        // 1: AW and W together, response on the next cycle
        fork
            send_aw(32'h10);
            send_w(32'hDEADBEEF, 4'hF);
        join
        wait_b(resp, cyc);
        chk("t1_bresp", 32'(resp), 32'h0);
        chk("t1_blat",  32'(cyc),  32'h0);
        send_ar(32'h10);
        wait_r(rd, rresp, cyc);
        chk("t1_rdata", rd, 32'hDEADBEEF);
        chk("t1_rresp", 32'(rresp), 32'h0);
        chk("t1_rlat",  32'(cyc), 32'h0);

        // 2: AW leads W by three cycles, then W leads AW
        send_aw(32'h20);
        repeat (2) @(posedge clk);
        #1;
        send_w(32'h11223344, 4'hF);
        wait_b(resp, cyc);
        chk("t2a_bresp", 32'(resp), 32'h0);
        send_w(32'h55667788, 4'hF);
        repeat (2) @(posedge clk);
        #1;
        send_aw(32'h24);
        wait_b(resp, cyc);
        chk("t2b_bresp", 32'(resp), 32'h0);
        read(32'h20, rd, rresp);
        chk("t2_rd20", rd, 32'h11223344);
        read(32'h24, rd, rresp);
        chk("t2_rd24", rd, 32'h55667788);

        // 3: partial strobes, then an all-zero strobe no-op
        write(32'h30, 32'hFFFFFFFF, 4'hF, resp);
        write(32'h30, 32'h00000000, 4'b0101, resp);
        read(32'h30, rd, rresp);
        chk("t3_strb", rd, 32'hFF00FF00);
        write(32'h30, 32'h12345678, 4'b0000, resp);
        chk("t3_nostrb_bresp", 32'(resp), 32'h0);
        read(32'h30, rd, rresp);
        chk("t3_nostrb", rd, 32'hFF00FF00);

        // 4: B held off five cycles while another write waits
        s_axi_bready = 1'b0;
        fork
            send_aw(32'h40);
            send_w(32'hA5A5A5A5, 4'hF);
        join
        fork
            send_aw(32'h44);
            send_w(32'h0F0F0F0F, 4'hF);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("t4_bvalid",  32'(s_axi_bvalid),  32'h1);
                    chk("t4_bresp",   32'(s_axi_bresp),   32'h0);
                    chk("t4_awready", 32'(s_axi_awready), 32'h0);
                    chk("t4_wready",  32'(s_axi_wready),  32'h0);
                end
                @(posedge clk);
                #1;
                s_axi_bready = 1'b1;
            end
        join
        wait_b(resp, cyc);
        chk("t4_bresp2", 32'(resp), 32'h0);

        // 4: R held off five cycles while another read waits
        s_axi_rready = 1'b0;
        send_ar(32'h40);
        fork
            send_ar(32'h44);
            begin
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("t4_rvalid",  32'(s_axi_rvalid),  32'h1);
                    chk("t4_rdata",   s_axi_rdata,        32'hA5A5A5A5);
                    chk("t4_arready", 32'(s_axi_arready), 32'h0);
                end
                @(posedge clk);
                #1;
                s_axi_rready = 1'b1;
            end
        join
        wait_r(rd, rresp, cyc);
        chk("t4_rd44", rd, 32'h0F0F0F0F);

        // 5: write and read of the same word on the same edge
        write(32'h50, 32'h000000AA, 4'hF, resp);
        fork
            send_aw(32'h50);
            send_w(32'h00000055, 4'hF);
            send_ar(32'h50);
        join
        fork
            wait_b(resp, cyc);
            wait_r(rd, rresp, cyc2);
        join
        chk("t5_old", rd, 32'h000000AA);
        chk("t5_bresp", 32'(resp), 32'h0);
        read(32'h50, rd, rresp);
        chk("t5_new", rd, 32'h00000055);

        // Reset with an AW parked: the stale address must never be written
        write(32'h60, 32'h11111111, 4'hF, resp);
        send_aw(32'h60);
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset("mid");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_w(32'h00000099, 4'hF);
        @(negedge clk);
        chk("mid_awready", 32'(s_axi_awready), 32'h1);
        chk("mid_wready",  32'(s_axi_wready),  32'h0);
        chk("mid_bvalid",  32'(s_axi_bvalid),  32'h0);
        @(posedge clk);
        #1;
        send_aw(32'h64);
        wait_b(resp, cyc);
        read(32'h60, rd, rresp);
        chk("mid_rd60", rd, 32'h11111111);
        read(32'h64, rd, rresp);
        chk("mid_rd64", rd, 32'h00000099);

        // 6: address just beyond the memory
        write(32'h0, 32'h12345678, 4'hF, resp);
        write(32'h1000, 32'hCAFEF00D, 4'hF, resp);
`ifdef AXIL_MEM_RANGE_CHK_EN
        chk("t6_bresp", 32'(resp), 32'h2);
        read(32'h1000, rd, rresp);
        chk("t6_rdata", rd, 32'h0);
        chk("t6_rresp", 32'(rresp), 32'h2);
        read(32'h0, rd, rresp);
        chk("t6_word0", rd, 32'h12345678);
`else
        chk("t6_bresp", 32'(resp), 32'h0);
        read(32'h1000, rd, rresp);
        chk("t6_rdata", rd, 32'hCAFEF00D);
        chk("t6_rresp", 32'(rresp), 32'h0);
        read(32'h0, rd, rresp);
        chk("t6_word0", rd, 32'hCAFEF00D);
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
